// File: rtl/tone_clk_gen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulator producing a tick strobe and square wave.
// Optional macro CLKDIV_DUTY_EN adds a programmable per-channel duty threshold for sq_out.
module tone_clk_gen #(
  parameter int CLK_HZ          = 27000000,
  parameter int ACC_W           = 32,
  parameter int NUM_CH          = 4,
  parameter int DEFAULT_FREQ_HZ = 22050,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_27MHz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              phase_sync,
  input  logic              inc_wr,
  input  logic [CH_W-1:0]   inc_ch,
  input  logic [ACC_W-1:0]  inc_data,
`ifdef CLKDIV_DUTY_EN
  input  logic              duty_wr,
  input  logic [CH_W-1:0]   duty_ch,
  input  logic [ACC_W-1:0]  duty_data,
`endif
  output logic [NUM_CH-1:0] inc_pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_out
);

  // Rounded DEFAULT_FREQ_HZ * 2^ACC_W / CLK_HZ, computed wide enough to avoid overflow.
  localparam int               CALC_W      = ACC_W + 48;
  localparam logic [CALC_W-1:0] W_CLK      = CALC_W'(CLK_HZ);
  localparam logic [CALC_W-1:0] W_NUM      = (CALC_W'(DEFAULT_FREQ_HZ) << ACC_W) + (W_CLK >> 1);
  localparam logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(W_NUM / W_CLK);

  logic [ACC_W-1:0]  r_acc      [NUM_CH];
  logic [ACC_W-1:0]  r_inc      [NUM_CH];
  logic [ACC_W-1:0]  r_pend_val [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] r_sq;

  logic [ACC_W:0]    w_sum      [NUM_CH];
  logic [NUM_CH-1:0] w_inc_hit;
  logic [NUM_CH-1:0] w_sq_next;

`ifdef CLKDIV_DUTY_EN
  localparam logic [ACC_W-1:0] DEFAULT_DUTY = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0]  r_duty      [NUM_CH];
  logic [ACC_W-1:0]  r_duty_pval [NUM_CH];
  logic [NUM_CH-1:0] r_duty_pend;
  logic [NUM_CH-1:0] w_duty_hit;
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum[i]     = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
      w_inc_hit[i] = inc_wr && (inc_ch == CH_W'(i));
`ifdef CLKDIV_DUTY_EN
      w_duty_hit[i] = duty_wr && (duty_ch == CH_W'(i));
      w_sq_next[i]  = (w_sum[i][ACC_W-1:0] < r_duty[i]);
`else
      w_sq_next[i]  = w_sum[i][ACC_W-1];
`endif
    end
  end

  // Sync and disable both force phase 0 and flush any pending increment, including one written this edge.
  always_ff @(posedge clk_27MHz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i]      <= '0;
        r_inc[i]      <= DEFAULT_INC;
        r_pend_val[i] <= '0;
      end
      r_pend <= '0;
      r_tick <= '0;
      r_sq   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (phase_sync || !ch_en[i]) begin
          r_acc[i]  <= '0;
          r_tick[i] <= 1'b0;
          r_sq[i]   <= 1'b0;
          r_pend[i] <= 1'b0;
          if (w_inc_hit[i]) begin
            r_inc[i] <= inc_data;
          end else if (r_pend[i]) begin
            r_inc[i] <= r_pend_val[i];
          end
        end else begin
          r_acc[i]  <= w_sum[i][ACC_W-1:0];
          r_tick[i] <= w_sum[i][ACC_W];
          r_sq[i]   <= w_sq_next[i];
          if (w_inc_hit[i]) begin
            r_pend_val[i] <= inc_data;
            r_pend[i]     <= 1'b1;
          end else if (w_sum[i][ACC_W] && r_pend[i]) begin
            r_inc[i]  <= r_pend_val[i];
            r_pend[i] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef CLKDIV_DUTY_EN
  always_ff @(posedge clk_27MHz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty[i]      <= DEFAULT_DUTY;
        r_duty_pval[i] <= '0;
      end
      r_duty_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (phase_sync || !ch_en[i]) begin
          r_duty_pend[i] <= 1'b0;
          if (w_duty_hit[i]) begin
            r_duty[i] <= duty_data;
          end else if (r_duty_pend[i]) begin
            r_duty[i] <= r_duty_pval[i];
          end
        end else if (w_duty_hit[i]) begin
          r_duty_pval[i] <= duty_data;
          r_duty_pend[i] <= 1'b1;
        end else if (w_sum[i][ACC_W] && r_duty_pend[i]) begin
          r_duty[i]      <= r_duty_pval[i];
          r_duty_pend[i] <= 1'b0;
        end
      end
    end
  end
`endif

  assign inc_pending = r_pend;
  assign tick        = r_tick;
  assign sq_out      = r_sq;

endmodule

// File: tb/tb_tone_clk_gen.sv
// Bench for tone_clk_gen: default-rate instance (tick counting) plus a small 8-bit instance checked against a model.
module tb_tone_clk_gen;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // Full-size instance at default parameters
  logic        b_reset = 1'b0;
  logic [3:0]  b_en    = '0;
  logic        b_sync  = 1'b0;
  logic        b_wr    = 1'b0;
  logic [1:0]  b_ch    = '0;
  logic [31:0] b_data  = '0;
  logic [3:0]  b_pend, b_tick, b_sq;

  tone_clk_gen u_big (
    .clk_27MHz(clk), .reset(b_reset), .ch_en(b_en), .phase_sync(b_sync),
    .inc_wr(b_wr), .inc_ch(b_ch), .inc_data(b_data),
    .inc_pending(b_pend), .tick(b_tick), .sq_out(b_sq)
  );

  // Small instance: ACC_W=8, DEFAULT_INC = round(32*256/256) = 32
  logic       s_reset = 1'b0;
  logic [2:0] s_en    = '0;
  logic       s_sync  = 1'b0;
  logic       s_wr    = 1'b0;
  logic [1:0] s_ch    = '0;
  logic [7:0] s_data  = '0;
  logic [2:0] s_pend, s_tick, s_sq;

  tone_clk_gen #(.CLK_HZ(256), .ACC_W(8), .NUM_CH(3), .DEFAULT_FREQ_HZ(32)) u_small (
    .clk_27MHz(clk), .reset(s_reset), .ch_en(s_en), .phase_sync(s_sync),
    .inc_wr(s_wr), .inc_ch(s_ch), .inc_data(s_data),
    .inc_pending(s_pend), .tick(s_tick), .sq_out(s_sq)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model of the small instance: integer phase, overflow when phase+inc reaches 256.
  int m_phase [3];
  int m_inc   [3];
  int m_pval  [3];
  bit [2:0] m_pend, m_tick, m_sq;

  initial begin
    for (int c = 0; c < 3; c++) begin
      m_phase[c] = 0; m_inc[c] = 32; m_pval[c] = 0;
    end
    m_pend = '0; m_tick = '0; m_sq = '0;
    forever begin
      @(posedge clk or negedge s_reset);
      if (!s_reset) begin
        for (int c = 0; c < 3; c++) begin
          m_phase[c] = 0; m_inc[c] = 32; m_pval[c] = 0;
        end
        m_pend = '0; m_tick = '0; m_sq = '0;
      end else begin
        for (int c = 0; c < 3; c++) begin
          bit written;
          int total;
          written = s_wr && (int'(s_ch) == c);
          if (s_sync || !s_en[c]) begin
            m_phase[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
            if (written) m_inc[c] = int'(s_data);
            else if (m_pend[c]) m_inc[c] = m_pval[c];
            m_pend[c] = 0;
          end else begin
            total      = m_phase[c] + m_inc[c];
            m_tick[c]  = (total >= 256);
            m_phase[c] = total % 256;
            m_sq[c]    = (m_phase[c] >= 128);
            if (written) begin
              m_pval[c] = int'(s_data);
              m_pend[c] = 1;
            end else if (m_tick[c] && m_pend[c]) begin
              m_inc[c]  = m_pval[c];
              m_pend[c] = 0;
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("model_tick", s_tick, m_tick);
      chk("model_sq",   s_sq,   m_sq);
      chk("model_pend", s_pend, m_pend);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int d);
    s_wr = 1'b1; s_ch = 2'(ch); s_data = 8'(d);
    @(negedge clk);
    s_wr = 1'b0;
  endtask

  // Edges until the next tick on channel ch, capped at bound.
  task automatic wait_tick(input int ch, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tick[ch] && n < bound);
  endtask

  int cnt   [4];
  int first [4];
  int n;
  logic [2:0] exp_sq [4];
  logic [2:0] exp_tk [4];

  initial begin
    step(10);
    chk_on = 1'b1;
    chk("rst_big_tick", b_tick, 4'h0);
    chk("rst_big_sq",   b_sq,   4'h0);
    chk("rst_big_pend", b_pend, 4'h0);
    chk("rst_small_out", {s_tick, s_sq, s_pend}, 9'h0);

    // 1 ms at 27 MHz = 27000 edges; 22050 Hz gives 22 ticks, first at edge 1225
    b_reset = 1'b1; b_en = 4'hF;
    for (int c = 0; c < 4; c++) begin cnt[c] = 0; first[c] = 0; end
    for (int k = 1; k <= 27000; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (b_tick[c]) begin
          cnt[c]++;
          if (first[c] == 0) first[c] = k;
        end
      end
    end
    for (int c = 0; c < 4; c++) chk("default_tick_count", cnt[c], 22);
    chk("default_first_tick", first[0], 1225);

    // Exact division: inc=64 then sync -> acc 64,128,192,0
    s_reset = 1'b1; s_en = 3'b111;
    wr(0, 64);
    s_sync = 1'b1; step(1); s_sync = 1'b0;
    chk("sync_pend_clear", s_pend, 3'b000);
    exp_sq[0] = 0; exp_sq[1] = 1; exp_sq[2] = 1; exp_sq[3] = 0;
    exp_tk[0] = 0; exp_tk[1] = 0; exp_tk[2] = 0; exp_tk[3] = 1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("div4_sq",   s_sq[0],   exp_sq[k]);
      chk("div4_tick", s_tick[0], exp_tk[k]);
    end

    // Shadowed update mid-period
    step(1);
    wr(0, 32);
    chk("shadow_pend_set", s_pend[0], 1'b1);
    step(1);
    chk("shadow_pend_hold", s_pend[0], 1'b1);
    step(1);
    chk("shadow_tick", s_tick[0], 1'b1);
    chk("shadow_pend_clr", s_pend[0], 1'b0);
    wait_tick(0, 20, n);
    chk("shadow_period8", n, 8);

    // Last write wins
    wr(0, 32);
    wr(0, 16);
    chk("overwrite_pend", s_pend[0], 1'b1);
    wait_tick(0, 20, n);
    chk("overwrite_old_period", n, 6);
    chk("overwrite_pend_clr", s_pend[0], 1'b0);
    wait_tick(0, 40, n);
    chk("overwrite_period16", n, 16);

    // Write landing on an overflow edge waits one more period
    step(15);
    wr(0, 64);
    chk("collide_tick", s_tick[0], 1'b1);
    chk("collide_pend", s_pend[0], 1'b1);
    wait_tick(0, 40, n);
    chk("collide_period16", n, 16);
    chk("collide_pend_clr", s_pend[0], 1'b0);
    wait_tick(0, 20, n);
    chk("collide_period4", n, 4);

    // Out-of-range channel write ignored
    wr(3, 8);
    chk("badch_pend", s_pend, 3'b000);
    wait_tick(0, 20, n);
    chk("badch_period", n, 3);

    // Disable mid-period applies the pending value and restarts from phase 0
    step(1);
    wr(0, 128);
    s_en = 3'b110; step(1);
    chk("dis_sq",   s_sq[0],   1'b0);
    chk("dis_tick", s_tick[0], 1'b0);
    chk("dis_pend", s_pend[0], 1'b0);
    s_en = 3'b111;
    wait_tick(0, 20, n);
    chk("reen_period2", n, 2);

    // Misalign ch2, then sync realigns ch1/ch2
    s_en = 3'b011; step(1); s_en = 3'b111;
    step(3);
    s_sync = 1'b1; step(1); s_sync = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk("sync_align", s_tick[2:1], (k % 8 == 0) ? 2'b11 : 2'b00);
    end

    // Async reset mid-cycle with a pending write
    wr(1, 200);
    chk("pre_reset_pend", s_pend[1], 1'b1);
    #2 s_reset = 1'b0;
    #1;
    chk("async_rst_tick", s_tick, 3'b000);
    chk("async_rst_sq",   s_sq,   3'b000);
    chk("async_rst_pend", s_pend, 3'b000);
    @(negedge clk);
    s_reset = 1'b1;
    wait_tick(1, 20, n);
    chk("post_reset_default_period", n, 8);
    chk("post_reset_pend", s_pend, 3'b000);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
